exc_seq: RTL and testbench

EXC_SEQ -- requirements
Module: exc_seq

---
 rtl/exc_seq_pkg.sv | 17 +
 rtl/exc_seq.sv | 116 +++++++++++
 tb/tb_exc_seq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/exc_seq_pkg.sv
// Shared encodings for the exception/ERET redirect sequencer.
package exc_seq_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrain = 2'd1,
        StRedir = 2'd2
    } state_e;

    typedef enum logic {
        KindExc  = 1'b0,
        KindEret = 1'b1
    } kind_e;

    localparam logic [31:0] DefaultHandlerPc = 32'h0000_4180;

endpackage

// File: rtl/exc_seq.sv
// Exception/ERET redirect sequencer: waits for memory traffic to drain, then flushes and redirects.
// Defining EXC_SEQ_CNT_EN adds a counter of exception redirects on exc_count.
module exc_seq
    import exc_seq_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = DefaultHandlerPc,
    parameter logic [7:0]  DRAIN_MAX  = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic        eret_m,
    input  logic [31:0] epc_i,
    input  logic        mem_busy,
    output logic        hold,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        exl_clr,
    output logic        drain_timeout,
    output logic [31:0] exc_count
);

    // Counter value seen in the last drain cycle allowed before forcing the redirect.
    localparam logic [7:0] DrainLast = DRAIN_MAX - 8'd1;

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic [31:0] target_q, target_d;
    logic [7:0]  drain_cnt_q, drain_cnt_d;
    logic        timeout_q, timeout_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            kind_q      <= KindExc;
            target_q    <= '0;
            drain_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            target_q    <= target_d;
            drain_cnt_q <= drain_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        target_d    = target_q;
        drain_cnt_d = drain_cnt_q;
        timeout_d   = timeout_q;
        unique case (state_q)
            StIdle: begin
                // An exception request takes priority over a simultaneous ERET.
                if (req_i || eret_m) begin
                    kind_d      = req_i ? KindExc : KindEret;
                    target_d    = req_i ? HANDLER_PC : epc_i;
                    drain_cnt_d = '0;
                    state_d     = mem_busy ? StDrain : StRedir;
                end
            end
            StDrain: begin
                if (!mem_busy) begin
                    state_d = StRedir;
                end else if (drain_cnt_q == DrainLast) begin
                    state_d   = StRedir;
                    timeout_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 8'd1;
                end
            end
            StRedir: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        hold           = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        exl_clr        = 1'b0;
        unique case (state_q)
            StDrain: hold = 1'b1;
            StRedir: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
                exl_clr        = (kind_q == KindEret);
            end
            default: ;
        endcase
    end

    assign drain_timeout = timeout_q;

`ifdef EXC_SEQ_CNT_EN
    logic [31:0] exc_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            exc_count_q <= '0;
        end else if (state_q == StRedir && kind_q == KindExc) begin
            exc_count_q <= exc_count_q + 32'd1;
        end
    end

    assign exc_count = exc_count_q;
`else
    assign exc_count = '0;
`endif

endmodule

// File: tb/tb_exc_seq.sv
// Bench for exc_seq: directed scenarios followed by random traffic, checked each cycle against
// a model that schedules every redirect from the whole stimulus table.
module tb_exc_seq;

    localparam int          N   = 2000;
    localparam int          M   = N + 16;
    localparam int          DM  = 4;
    localparam logic [31:0] HPC = 32'h0000_4180;
`ifdef EXC_SEQ_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_i = 1'b0;
    logic        eret_m = 1'b0;
    logic [31:0] epc_i = '0;
    logic        mem_busy = 1'b0;
    logic        hold, flush, redirect_valid, exl_clr, drain_timeout;
    logic [31:0] redirect_pc, exc_count;

    exc_seq #(
        .HANDLER_PC(HPC),
        .DRAIN_MAX (8'(DM))
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_i         (req_i),
        .eret_m        (eret_m),
        .epc_i         (epc_i),
        .mem_busy      (mem_busy),
        .hold          (hold),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .exl_clr       (exl_clr),
        .drain_timeout (drain_timeout),
        .exc_count     (exc_count)
    );

    always #5 clk = ~clk;

    bit          rst_a [M];
    bit          req_a [M];
    bit          eret_a[M];
    bit          busy_a[M];
    logic [31:0] epc_a [M];
    bit          exp_hold[M];
    bit          exp_rv  [M];
    bit          exp_exl [M];
    bit          exp_to  [M];
    logic [31:0] exp_pc  [M];
    logic [31:0] exp_cnt [M];
    bit          redir_exc[M];
    bit          to_set   [M];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit running = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Single compare process: model every cycle, plus literal pins on the directed cycles.
    always @(negedge clk) begin
        if (running && cyc >= 1) begin
            check("hold", {31'd0, hold}, {31'd0, exp_hold[cyc]});
            check("flush", {31'd0, flush}, {31'd0, exp_rv[cyc]});
            check("redirect_valid", {31'd0, redirect_valid}, {31'd0, exp_rv[cyc]});
            check("redirect_pc", redirect_pc, exp_pc[cyc]);
            check("exl_clr", {31'd0, exl_clr}, {31'd0, exp_exl[cyc]});
            check("drain_timeout", {31'd0, drain_timeout}, {31'd0, exp_to[cyc]});
            check("exc_count", exc_count, exp_cnt[cyc]);
            case (cyc)
                2: check("lit_reset_pc", redirect_pc, 32'h0);
                3: begin
                    check("lit_exc_rv", {31'd0, redirect_valid}, 32'd1);
                    check("lit_exc_pc", redirect_pc, 32'h4180);
                    check("lit_exc_exl", {31'd0, exl_clr}, 32'd0);
                end
                4: check("lit_exc_cnt", exc_count, CntEn ? 32'd1 : 32'd0);
                5: begin
                    check("lit_eret_pc", redirect_pc, 32'h3008);
                    check("lit_eret_exl", {31'd0, exl_clr}, 32'd1);
                    check("lit_eret_flush", {31'd0, flush}, 32'd1);
                end
                6: check("lit_eret_cnt", exc_count, CntEn ? 32'd1 : 32'd0);
                9: check("lit_drain_hold", {31'd0, hold}, 32'd1);
                10: begin
                    check("lit_drain_rv", {31'd0, redirect_valid}, 32'd1);
                    check("lit_drain_to", {31'd0, drain_timeout}, 32'd0);
                end
                12: begin
                    check("lit_both_pc", redirect_pc, 32'h4180);
                    check("lit_both_exl", {31'd0, exl_clr}, 32'd0);
                end
                17: check("lit_tmo_hold", {31'd0, hold}, 32'd1);
                18: begin
                    check("lit_tmo_rv", {31'd0, redirect_valid}, 32'd1);
                    check("lit_tmo_to", {31'd0, drain_timeout}, 32'd1);
                end
                20: check("lit_tmo_sticky", {31'd0, drain_timeout}, 32'd1);
                23: check("lit_abort_hold", {31'd0, hold}, 32'd1);
                24: begin
                    check("lit_abort_outs", {27'd0, hold, flush, redirect_valid, exl_clr,
                                             drain_timeout}, 32'd0);
                    check("lit_abort_pc", redirect_pc, 32'h0);
                end
                default: ;
            endcase
        end
    end

    initial begin
        int          free, r, c_rst, c_end;
        bit          forced;
        bit          to;
        logic [31:0] cnt;

        for (int t = 0; t < M; t++) begin
            rst_a[t] = 0; req_a[t] = 0; eret_a[t] = 0; busy_a[t] = 0; epc_a[t] = '0;
            exp_hold[t] = 0; exp_rv[t] = 0; exp_exl[t] = 0; exp_to[t] = 0;
            exp_pc[t] = '0; exp_cnt[t] = '0; redir_exc[t] = 0; to_set[t] = 0;
        end
        // Directed prefix: reset, plain exception, ERET, short drain, collision, timeout, abort.
        rst_a[0] = 1; rst_a[1] = 1;
        req_a[2] = 1;
        eret_a[4] = 1; epc_a[4] = 32'h3008;
        req_a[6] = 1; busy_a[6] = 1; busy_a[7] = 1; busy_a[8] = 1;
        req_a[11] = 1; eret_a[11] = 1; epc_a[11] = 32'h3000;
        req_a[13] = 1;
        for (int t = 13; t <= 24; t++) busy_a[t] = 1;
        req_a[21] = 1;
        rst_a[23] = 1;
        for (int t = 25; t < N; t++) begin
            rst_a[t]  = ($urandom_range(0, 149) == 0);
            req_a[t]  = (t < N - 12) && ($urandom_range(0, 5) == 0);
            eret_a[t] = (t < N - 12) && ($urandom_range(0, 4) == 0);
            busy_a[t] = busy_a[t-1] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
            epc_a[t]  = $urandom;
        end

        // Schedule each accepted event: drain until busy drops or DM busy drain cycles elapse.
        free = 0;
        for (int t = 0; t < N; t++) begin
            if (t < free || rst_a[t] || !(req_a[t] || eret_a[t])) continue;
            forced = 1'b0;
            if (!busy_a[t]) begin
                r = t + 1;
            end else begin
                forced = 1'b1;
                r = t + 1 + DM;
                for (int d = 0; d < DM; d++) begin
                    if (!busy_a[t+1+d]) begin
                        r = t + 2 + d;
                        forced = 1'b0;
                        break;
                    end
                end
            end
            c_rst = -1;
            for (int c = t + 1; c < r; c++) if (rst_a[c] && c_rst < 0) c_rst = c;
            c_end = (c_rst >= 0) ? c_rst + 1 : r;
            for (int c = t + 1; c < c_end; c++) exp_hold[c] = 1;
            if (c_rst >= 0) begin
                free = c_rst + 1;
            end else begin
                exp_rv[r]    = 1;
                exp_pc[r]    = req_a[t] ? HPC : epc_a[t];
                exp_exl[r]   = !req_a[t];
                redir_exc[r] = req_a[t];
                to_set[r]    = forced;
                free = r + 1;
            end
        end
        to = 0;
        cnt = '0;
        for (int t = 1; t < M; t++) begin
            if (rst_a[t-1]) begin
                to = 0;
                cnt = '0;
            end else if (redir_exc[t-1]) begin
                cnt = cnt + 32'd1;
            end
            if (to_set[t]) to = 1;
            exp_to[t]  = to;
            exp_cnt[t] = CntEn ? cnt : 32'd0;
        end

        @(posedge clk);
        #1;
        running = 1'b1;
        for (int t = 0; t < N; t++) begin
            cyc      = t;
            reset    = rst_a[t];
            req_i    = req_a[t];
            eret_m   = eret_a[t];
            epc_i    = epc_a[t];
            mem_busy = busy_a[t];
            @(posedge clk);
            #1;
        end
        running = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
